// File: rtl/axi_adc_pkg.sv
// Shared definitions for the AXI_ADC register block: register word indices,
// AXI response codes, write FSM states and the byte-lane merge helper.
package axi_adc_pkg;

    // Word indices (addr[4:2]) of the register map.
    localparam logic [2:0] RegCtrl   = 3'd0;  // 0x00 RW, bit 0 = capture enable
    localparam logic [2:0] RegCfg    = 3'd1;  // 0x04 RW
    localparam logic [2:0] RegScr2   = 3'd2;  // 0x08 RW scratch
    localparam logic [2:0] RegScr3   = 3'd3;  // 0x0C RW scratch
    localparam logic [2:0] RegSample = 3'd4;  // 0x10 RO, NEW flag + last sample
    localparam logic [2:0] RegCount  = 3'd5;  // 0x14 RO, captured-sample counter

    typedef enum logic [1:0] {
        RespOkay   = 2'b00,
        RespSlverr = 2'b10
    } axi_resp_t;

    // HaveAw/HaveW mean exactly one holding buffer is full.
    typedef enum logic [1:0] {
        StIdle,
        StHaveAw,
        StHaveW,
        StResp
    } wr_state_e;

    // Merge write data into the current value, one byte lane per strobe bit.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] cur,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = wstrb[i] ? wdata[i*8 +: 8] : cur[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_adc_capture.sv
// ADC sample capture: last-sample latch, sticky NEW flag and a wrapping
// 32-bit count of captured samples. Presents SAMPLE as a ready-made read word.
module axi_adc_capture
    import axi_adc_pkg::*;
#(
    parameter int unsigned AdcWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic                clr_new_i,
    input  logic [AdcWidth-1:0] adc_data_i,
    input  logic                adc_valid_i,
    output logic [31:0]         sample_o,
    output logic [31:0]         count_o
);

    logic [AdcWidth-1:0] sample_q, sample_d;
    logic                new_q, new_d;
    logic [31:0]         count_q, count_d;
    logic                capture;

    assign capture = enable_i && adc_valid_i;

    // Next-state: a capture wins over a coincident read-clear of NEW.
    always_comb begin
        sample_d = sample_q;
        new_d    = new_q;
        count_d  = count_q;
        if (capture) begin
            sample_d = adc_data_i;
            new_d    = 1'b1;
            count_d  = count_q + 32'd1;
        end else if (clr_new_i) begin
            new_d = 1'b0;
        end
    end

    // Capture state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sample_q <= '0;
            new_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            sample_q <= sample_d;
            new_q    <= new_d;
            count_q  <= count_d;
        end
    end

    assign sample_o = {new_q, {(31 - AdcWidth){1'b0}}, sample_q};
    assign count_o  = count_q;

endmodule

// File: rtl/axi_adc_regs.sv
// AXI4-Lite responder for the AXI_ADC IP: four RW control registers, the
// read-only SAMPLE/COUNT capture registers, and software-gated ADC capture.
module axi_adc_regs
    import axi_adc_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int C_ADC_WIDTH        = 16
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    input  logic [C_ADC_WIDTH-1:0]          adc_data_i,
    input  logic                            adc_valid_i,
    output logic [31:0]                     ctrl_o,
    output logic [31:0]                     cfg_o
);

    wr_state_e                       state_q, state_d;
    logic                            ready_en_q;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   awaddr_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]   wdata_q;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb_q;
    axi_resp_t                       bresp_q;
    logic [31:0]                     regs_q [4];
    logic [31:0]                     regs_d [4];

    logic                            rvalid_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]   rdata_q;
    axi_resp_t                       rresp_q;
    logic                            rd_sample_q;

    logic                            aw_hs, w_hs, ar_hs, r_hs;
    logic                            commit;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   wr_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0]   wr_data;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] wr_strb;
    logic [2:0]                      wr_idx, rd_idx;
    logic                            wr_ok;
    logic [31:0]                     rd_data;
    axi_resp_t                       rd_resp;
    logic [31:0]                     sample_word, count_word;
    logic                            unused_bits;

    // Handshakes and ready/valid outputs. Readies stay low until the first
    // edge after reset so that nothing is accepted during reset.
    assign s_axi_awready = ready_en_q && (state_q == StIdle || state_q == StHaveW);
    assign s_axi_wready  = ready_en_q && (state_q == StIdle || state_q == StHaveAw);
    assign s_axi_bvalid  = (state_q == StResp);
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = ready_en_q && !rvalid_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign r_hs  = rvalid_q && s_axi_rready;

    // Commit uses the buffered half if present, otherwise the live bus.
    assign wr_addr = (state_q == StHaveAw) ? awaddr_q : s_axi_awaddr;
    assign wr_data = (state_q == StHaveW) ? wdata_q : s_axi_wdata;
    assign wr_strb = (state_q == StHaveW) ? wstrb_q : s_axi_wstrb;
    assign wr_idx  = wr_addr[4:2];
    assign wr_ok   = wr_idx inside {RegCtrl, RegCfg, RegScr2, RegScr3};
    assign rd_idx  = s_axi_araddr[4:2];

    assign unused_bits = ^{s_axi_awprot, s_axi_arprot, wr_addr[1:0], s_axi_araddr[1:0]};

    // Write FSM next-state; commit fires on the edge the second half arrives.
    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (aw_hs && w_hs) begin
                    commit  = 1'b1;
                    state_d = StResp;
                end else if (aw_hs) begin
                    state_d = StHaveAw;
                end else if (w_hs) begin
                    state_d = StHaveW;
                end
            end
            StHaveAw: begin
                if (w_hs) begin
                    commit  = 1'b1;
                    state_d = StResp;
                end
            end
            StHaveW: begin
                if (aw_hs) begin
                    commit  = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (s_axi_bready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Register file next-state: byte-lane merge on a committed RW write.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (commit && wr_ok) begin
            regs_d[wr_idx[1:0]] = apply_wstrb(regs_q[wr_idx[1:0]], wr_data, wr_strb);
        end
    end

    // Write-side state: FSM, holding buffers, response code, register file.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q    <= StIdle;
            ready_en_q <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RespOkay;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
            if (aw_hs) begin
                awaddr_q <= s_axi_awaddr;
            end
            if (w_hs) begin
                wdata_q <= s_axi_wdata;
                wstrb_q <= s_axi_wstrb;
            end
            if (commit) begin
                bresp_q <= wr_ok ? RespOkay : RespSlverr;
            end
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read data mux; unmapped words return SLVERR with zero data.
    always_comb begin
        rd_data = '0;
        rd_resp = RespOkay;
        case (rd_idx)
            RegCtrl, RegCfg, RegScr2, RegScr3: rd_data = regs_q[rd_idx[1:0]];
            RegSample:                         rd_data = sample_word;
            RegCount:                          rd_data = count_word;
            default:                           rd_resp = RespSlverr;
        endcase
    end

    // Read channel: data captured at the AR handshake, held until RREADY.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= RespOkay;
            rd_sample_q <= 1'b0;
        end else if (ar_hs) begin
            rvalid_q    <= 1'b1;
            rdata_q     <= rd_data;
            rresp_q     <= rd_resp;
            rd_sample_q <= (rd_idx == RegSample);
        end else if (r_hs) begin
            rvalid_q <= 1'b0;
        end
    end

    axi_adc_capture #(
        .AdcWidth (C_ADC_WIDTH)
    ) u_capture (
        .clk_i       (ACLK),
        .rst_i       (ARESET),
        .enable_i    (regs_q[0][0]),
        .clr_new_i   (r_hs && rd_sample_q),
        .adc_data_i  (adc_data_i),
        .adc_valid_i (adc_valid_i),
        .sample_o    (sample_word),
        .count_o     (count_word)
    );

    assign ctrl_o = regs_q[0];
    assign cfg_o  = regs_q[1];

endmodule

// File: tb/tb_axi_adc_regs.sv
// Directed self-checking bench for axi_adc_regs. Inputs change and outputs
// are sampled on the falling edge; the DUT acts on the rising edge.
module tb_axi_adc_regs;

    logic        ACLK;
    logic        ARESET;
    logic [4:0]  s_axi_awaddr;
    logic [2:0]  s_axi_awprot;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [4:0]  s_axi_araddr;
    logic [2:0]  s_axi_arprot;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [15:0] adc_data;
    logic        adc_valid;
    logic [31:0] ctrl;
    logic [31:0] cfg;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int tmo_cnt   = 0;

    axi_adc_regs #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (5),
        .C_ADC_WIDTH        (16)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awprot  (s_axi_awprot),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arprot  (s_axi_arprot),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .adc_data_i    (adc_data),
        .adc_valid_i   (adc_valid),
        .ctrl_o        (ctrl),
        .cfg_o         (cfg)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Full write with AW and W presented together; returns BRESP.
    task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] r);
        bit aw_done, w_done, hs_aw, hs_w;
        int n;
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        aw_done = 0; w_done = 0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            hs_aw = s_axi_awvalid && s_axi_awready;
            hs_w  = s_axi_wvalid && s_axi_wready;
            @(negedge ACLK); n++;
            if (hs_aw) begin s_axi_awvalid = 1'b0; aw_done = 1; end
            if (hs_w)  begin s_axi_wvalid  = 1'b0; w_done  = 1; end
        end
        if (!(aw_done && w_done)) begin
            tmo_cnt++; s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        end
        n = 0;
        while (!s_axi_bvalid && n < 20) begin @(negedge ACLK); n++; end
        if (!s_axi_bvalid) tmo_cnt++;
        r = s_axi_bresp;
        @(negedge ACLK);
    endtask

    // Full read with RREADY high; returns RDATA and RRESP.
    task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
        int n;
        s_axi_araddr = a; s_axi_arvalid = 1'b1; n = 0;
        while (!s_axi_arready && n < 20) begin @(negedge ACLK); n++; end
        if (!s_axi_arready) tmo_cnt++;
        @(negedge ACLK);
        s_axi_arvalid = 1'b0;
        n = 0;
        while (!s_axi_rvalid && n < 20) begin @(negedge ACLK); n++; end
        if (!s_axi_rvalid) tmo_cnt++;
        d = s_axi_rdata; r = s_axi_rresp;
        @(negedge ACLK);
    endtask

    task automatic pulse_adc(input logic [15:0] v);
        adc_data = v; adc_valid = 1'b1;
        @(negedge ACLK);
        adc_valid = 1'b0;
        @(negedge ACLK);
    endtask

    task automatic test_reset;
        logic [107:0] outs;
        repeat (3) @(negedge ACLK);
        outs = {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid,
                s_axi_bresp, s_axi_rresp, s_axi_rdata, ctrl, cfg};
        total_cnt++;
        if (outs !== '0) $display("FAIL reset_outputs: got %h expected 0", outs);
        else pass_cnt++;
        ARESET = 1'b0;
        #1;
        total_cnt++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b000)
            $display("FAIL ready_before_first_edge: got %b expected 000",
                     {s_axi_awready, s_axi_wready, s_axi_arready});
        else pass_cnt++;
        @(negedge ACLK);
        total_cnt++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111)
            $display("FAIL ready_after_release: got %b expected 111",
                     {s_axi_awready, s_axi_wready, s_axi_arready});
        else pass_cnt++;
    endtask

    task automatic test_w_before_aw;
        logic [31:0] d;
        logic [1:0]  r;
        s_axi_wdata = 32'hDEADBEEF; s_axi_wstrb = 4'b0101; s_axi_awaddr = 5'h08;
        s_axi_wvalid = 1'b1;
        @(negedge ACLK);
        s_axi_wvalid = 1'b0;
        total_cnt++;
        if ({s_axi_wready, s_axi_awready, s_axi_bvalid} !== 3'b010)
            $display("FAIL w_buffered: got %b expected 010",
                     {s_axi_wready, s_axi_awready, s_axi_bvalid});
        else pass_cnt++;
        repeat (2) @(negedge ACLK);
        s_axi_awvalid = 1'b1;
        total_cnt++;
        if (s_axi_bvalid !== 1'b0) $display("FAIL bvalid_early: got %b expected 0", s_axi_bvalid);
        else pass_cnt++;
        @(negedge ACLK);
        s_axi_awvalid = 1'b0;
        total_cnt++;
        if ({s_axi_bvalid, s_axi_bresp} !== 3'b100)
            $display("FAIL bvalid_after_aw: got %b expected 100", {s_axi_bvalid, s_axi_bresp});
        else pass_cnt++;
        @(negedge ACLK);
        axi_read(5'h08, d, r);
        total_cnt++;
        if ({r, d} !== {2'b00, 32'h00AD00EF})
            $display("FAIL wstrb_merge: got %h expected %h", {r, d}, {2'b00, 32'h00AD00EF});
        else pass_cnt++;
    endtask

    task automatic test_rw_basic;
        logic [31:0] d;
        logic [1:0]  r;
        for (int i = 0; i < 4; i++) begin
            axi_write(5'(i * 4), 32'(i + 1), 4'hF, r);
            total_cnt++;
            if (r !== 2'b00) $display("FAIL write_resp_%0d: got %b expected 00", i, r);
            else pass_cnt++;
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(5'(i * 4), d, r);
            total_cnt++;
            if ({r, d} !== {2'b00, 32'(i + 1)})
                $display("FAIL readback_%0d: got %h expected %h", i, {r, d}, {2'b00, 32'(i + 1)});
            else pass_cnt++;
        end
        total_cnt++;
        if ({ctrl, cfg} !== {32'd1, 32'd2})
            $display("FAIL ctrl_cfg_out: got %h expected %h", {ctrl, cfg}, {32'd1, 32'd2});
        else pass_cnt++;
    endtask

    task automatic test_slverr;
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(5'h10, 32'hFFFFFFFF, 4'hF, r);
        total_cnt++;
        if (r !== 2'b10) $display("FAIL ro_write_resp: got %b expected 10", r);
        else pass_cnt++;
        axi_write(5'h1C, 32'h12345678, 4'hF, r);
        total_cnt++;
        if (r !== 2'b10) $display("FAIL unmapped_write_resp: got %b expected 10", r);
        else pass_cnt++;
        axi_read(5'h10, d, r);
        total_cnt++;
        if ({r, d} !== {2'b00, 32'h0}) $display("FAIL sample_unchanged: got %h expected 0", {r, d});
        else pass_cnt++;
        axi_read(5'h18, d, r);
        total_cnt++;
        if ({r, d} !== {2'b10, 32'h0})
            $display("FAIL unmapped_read: got %h expected %h", {r, d}, {2'b10, 32'h0});
        else pass_cnt++;
    endtask

    task automatic test_capture;
        logic [31:0] d;
        logic [1:0]  r;
        logic [15:0] vals [3];
        vals[0] = 16'h0123; vals[1] = 16'h0456; vals[2] = 16'h0789;
        for (int i = 0; i < 3; i++) pulse_adc(vals[i]);
        axi_read(5'h10, d, r);
        total_cnt++;
        if (d !== 32'h80000789) $display("FAIL sample_new: got %h expected 80000789", d);
        else pass_cnt++;
        axi_read(5'h14, d, r);
        total_cnt++;
        if (d !== 32'd3) $display("FAIL count3: got %h expected 3", d);
        else pass_cnt++;
        axi_read(5'h10, d, r);
        total_cnt++;
        if (d !== 32'h00000789) $display("FAIL sample_new_cleared: got %h expected 00000789", d);
        else pass_cnt++;
        // SAMPLE read completes on the same edge as a capture.
        s_axi_araddr = 5'h10; s_axi_arvalid = 1'b1;
        @(negedge ACLK);
        s_axi_arvalid = 1'b0;
        d = s_axi_rdata;
        adc_data = 16'h0BBB; adc_valid = 1'b1;
        @(negedge ACLK);
        adc_valid = 1'b0;
        total_cnt++;
        if (d !== 32'h00000789) $display("FAIL coincident_rdata: got %h expected 00000789", d);
        else pass_cnt++;
        axi_read(5'h10, d, r);
        total_cnt++;
        if (d !== 32'h80000BBB) $display("FAIL capture_wins: got %h expected 80000bbb", d);
        else pass_cnt++;
        // CTRL cleared by a write; a sample on the commit edge still lands.
        s_axi_awaddr = 5'h00; s_axi_wdata = 32'h0; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        adc_data = 16'h0CCC; adc_valid = 1'b1;
        @(negedge ACLK);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        pulse_adc(16'h0DDD);
        axi_read(5'h10, d, r);
        total_cnt++;
        if (d !== 32'h80000CCC) $display("FAIL commit_edge_capture: got %h expected 80000ccc", d);
        else pass_cnt++;
        axi_read(5'h14, d, r);
        total_cnt++;
        if (d !== 32'd5) $display("FAIL count_after_disable: got %h expected 5", d);
        else pass_cnt++;
        total_cnt++;
        if (ctrl !== 32'h0) $display("FAIL ctrl_cleared: got %h expected 0", ctrl);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        logic [1:0]  r;
        s_axi_awaddr = 5'h0C; s_axi_wdata = 32'h11; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        @(negedge ACLK);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        total_cnt++;
        if ({s_axi_bvalid, s_axi_awready} !== 2'b10)
            $display("FAIL wr_cycle1: got %b expected 10", {s_axi_bvalid, s_axi_awready});
        else pass_cnt++;
        @(negedge ACLK);
        total_cnt++;
        if ({s_axi_bvalid, s_axi_awready} !== 2'b01)
            $display("FAIL wr_cycle2: got %b expected 01", {s_axi_bvalid, s_axi_awready});
        else pass_cnt++;
        // Read and write of REG3 handshake on the same edge: read sees old value.
        s_axi_awaddr = 5'h0C; s_axi_wdata = 32'h22; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        s_axi_araddr = 5'h0C; s_axi_arvalid = 1'b1;
        @(negedge ACLK);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        total_cnt++;
        if ({s_axi_rvalid, s_axi_arready, s_axi_rdata} !== {2'b10, 32'h11})
            $display("FAIL rd_old_value: got %h expected %h",
                     {s_axi_rvalid, s_axi_arready, s_axi_rdata}, {2'b10, 32'h11});
        else pass_cnt++;
        @(negedge ACLK);
        total_cnt++;
        if ({s_axi_rvalid, s_axi_arready} !== 2'b01)
            $display("FAIL rd_cycle2: got %b expected 01", {s_axi_rvalid, s_axi_arready});
        else pass_cnt++;
        axi_read(5'h0C, d, r);
        total_cnt++;
        if (d !== 32'h22) $display("FAIL rd_new_value: got %h expected 22", d);
        else pass_cnt++;
    endtask

    task automatic test_backpressure;
        logic [35:0] rd_obs;
        s_axi_bready = 1'b0;
        s_axi_awaddr = 5'h04; s_axi_wdata = 32'hCAFE0001; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        @(negedge ACLK);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            total_cnt++;
            if ({s_axi_bvalid, s_axi_bresp, s_axi_awready, s_axi_wready} !== 5'b10000)
                $display("FAIL b_stall_%0d: got %b expected 10000", k,
                         {s_axi_bvalid, s_axi_bresp, s_axi_awready, s_axi_wready});
            else pass_cnt++;
            @(negedge ACLK);
        end
        s_axi_bready = 1'b1;
        @(negedge ACLK);
        total_cnt++;
        if (s_axi_bvalid !== 1'b0) $display("FAIL b_release: got %b expected 0", s_axi_bvalid);
        else pass_cnt++;
        s_axi_rready = 1'b0;
        s_axi_araddr = 5'h04; s_axi_arvalid = 1'b1;
        @(negedge ACLK);
        s_axi_arvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rd_obs = {s_axi_rvalid, s_axi_rresp, s_axi_rdata, s_axi_arready};
            total_cnt++;
            if (rd_obs !== {1'b1, 2'b00, 32'hCAFE0001, 1'b0})
                $display("FAIL r_stall_%0d: got %h expected %h", k, rd_obs,
                         {1'b1, 2'b00, 32'hCAFE0001, 1'b0});
            else pass_cnt++;
            @(negedge ACLK);
        end
        s_axi_rready = 1'b1;
        @(negedge ACLK);
        total_cnt++;
        if (s_axi_rvalid !== 1'b0) $display("FAIL r_release: got %b expected 0", s_axi_rvalid);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        logic [107:0] outs;
        logic [31:0]  d;
        logic [1:0]   r;
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        s_axi_awaddr = 5'h00; s_axi_wdata = 32'h5; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        s_axi_araddr = 5'h04; s_axi_arvalid = 1'b1;
        @(negedge ACLK);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        total_cnt++;
        if ({s_axi_bvalid, s_axi_rvalid, ctrl} !== {2'b11, 32'h5})
            $display("FAIL pre_reset_pending: got %h expected %h",
                     {s_axi_bvalid, s_axi_rvalid, ctrl}, {2'b11, 32'h5});
        else pass_cnt++;
        ARESET = 1'b1;
        #1;
        outs = {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid,
                s_axi_bresp, s_axi_rresp, s_axi_rdata, ctrl, cfg};
        total_cnt++;
        if (outs !== '0) $display("FAIL mid_reset_outputs: got %h expected 0", outs);
        else pass_cnt++;
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        total_cnt++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid} !== 4'b1110)
            $display("FAIL post_reset_ready: got %b expected 1110",
                     {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid});
        else pass_cnt++;
        axi_write(5'h04, 32'h77, 4'hF, r);
        total_cnt++;
        if (r !== 2'b00) $display("FAIL post_reset_write: got %b expected 00", r);
        else pass_cnt++;
        axi_read(5'h04, d, r);
        total_cnt++;
        if ({r, d} !== {2'b00, 32'h77}) $display("FAIL post_reset_read: got %h expected 77", {r, d});
        else pass_cnt++;
        axi_read(5'h08, d, r);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL reg2_cleared: got %h expected 0", d);
        else pass_cnt++;
        axi_read(5'h14, d, r);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL count_cleared: got %h expected 0", d);
        else pass_cnt++;
    endtask

    initial begin
        ARESET = 1'b1;
        s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
        s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
        adc_data = '0; adc_valid = 1'b0;

        test_reset();
        test_w_before_aw();
        test_rw_basic();
        test_slverr();
        test_capture();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();

        total_cnt++;
        if (tmo_cnt !== 0) $display("FAIL handshake_timeouts: got %0d expected 0", tmo_cnt);
        else pass_cnt++;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
